// File: rtl/axis_gen_pkg.sv
// Shared encodings and LFSR helpers for the AXI4-Stream pattern generator.
package axis_gen_pkg;

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_LFSR    = 2'd1,
        MODE_INDEX   = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return {1'b0, q[31:1]} ^ (q[0] ? LFSR_POLY : 32'h0);
    endfunction

    function automatic logic [31:0] lfsr_seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR; load takes priority over step, and a zero seed becomes 1.
module lfsr32_galois
    import axis_gen_pkg::*;
(
    input  logic        aclk,
    input  logic        areset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] q
);

    logic [31:0] r_q;

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_q <= 32'h1;
        end else if (load) begin
            r_q <= lfsr_seed_fix(seed);
        end else if (step) begin
            r_q <= lfsr_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/axis_pattern_gen.sv
// Framed AXI4-Stream traffic source: counter, LFSR or index patterns with
// configurable packet length, inter-packet gap and packet count.
module axis_pattern_gen
    import axis_gen_pkg::*;
#(
    parameter int TDATA_BITS = 32,
    parameter int LEN_BITS   = 16,
    parameter int GAP_BITS   = 8,
    parameter int CNT_BITS   = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            cfg_mode,
    input  logic [TDATA_BITS-1:0] cfg_seed,
    input  logic [LEN_BITS-1:0]   cfg_pkt_len,
    input  logic [GAP_BITS-1:0]   cfg_gap,
    input  logic [CNT_BITS-1:0]   cfg_pkt_count,
    output logic [TDATA_BITS-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_BITS-1:0]   pkts_sent,
    output logic [CNT_BITS-1:0]   beats_sent
);

    localparam int HALF = TDATA_BITS / 2;

    state_e                r_state;
    state_e                w_state_next;
    mode_e                 r_mode;
    logic [LEN_BITS-1:0]   r_len;
    logic [LEN_BITS-1:0]   r_beat_idx;
    logic [GAP_BITS-1:0]   r_gap;
    logic [GAP_BITS-1:0]   r_gap_cnt;
    logic [CNT_BITS-1:0]   r_pkt_count;
    logic [CNT_BITS-1:0]   r_pkts_sent;
    logic [CNT_BITS-1:0]   r_beats_sent;
    logic                  r_stop_pending;
    logic [TDATA_BITS-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_start_ok;
    logic                  w_hs;
    logic                  w_stop_seen;
    logic                  w_count_hit;
    mode_e                 w_cfg_mode;
    logic [LEN_BITS-1:0]   w_cfg_len;
    logic [31:0]           w_seed32;
    logic [31:0]           w_lfsr_q;
    logic [LEN_BITS-1:0]   w_beat_next;
    logic [CNT_BITS-1:0]   w_pkt_next;
    logic [TDATA_BITS-1:0] w_data_next;
    logic [TDATA_BITS-1:0] w_first_data;

    assign w_start_ok  = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_hs        = r_tvalid && m_axis_tready;
    assign w_stop_seen = r_stop_pending || stop;
    assign w_count_hit = (r_pkt_count != '0) && (r_pkts_sent + CNT_BITS'(1) == r_pkt_count);
    assign w_cfg_mode  = (mode_e'(cfg_mode) == MODE_RSVD) ? MODE_COUNTER : mode_e'(cfg_mode);
    assign w_cfg_len   = (cfg_pkt_len == '0) ? LEN_BITS'(1) : cfg_pkt_len;
    assign w_seed32    = lfsr_seed_fix(32'(cfg_seed));
    assign w_beat_next = r_tlast ? '0 : r_beat_idx + LEN_BITS'(1);
    assign w_pkt_next  = r_tlast ? r_pkts_sent + CNT_BITS'(1) : r_pkts_sent;

    lfsr32_galois u_lfsr (
        .aclk   (aclk),
        .areset (areset),
        .load   (w_start_ok),
        .seed   (32'(cfg_seed)),
        .step   (r_state == ST_SEND && w_hs),
        .q      (w_lfsr_q)
    );

    // Output data is registered, so the value for the next beat is computed one step ahead.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_data_next  = r_tdata + TDATA_BITS'(1);
        w_first_data = cfg_seed;
        case (r_mode)
            MODE_LFSR:  w_data_next = TDATA_BITS'(lfsr_next(w_lfsr_q));
            MODE_INDEX: w_data_next = {HALF'(w_pkt_next), HALF'(w_beat_next)};
            default:    ;
        endcase
        case (w_cfg_mode)
            MODE_LFSR:  w_first_data = TDATA_BITS'(w_seed32);
            MODE_INDEX: w_first_data = '0;
            default:    ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_hs && r_tlast) begin
                    if (w_count_hit)        w_state_next = ST_DONE;
                    else if (w_stop_seen)   w_state_next = ST_IDLE;
                    else if (r_gap != '0)   w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_stop_seen)                         w_state_next = ST_IDLE;
                else if (r_gap_cnt == GAP_BITS'(1))      w_state_next = ST_SEND;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state        <= ST_IDLE;
            r_mode         <= MODE_COUNTER;
            r_len          <= '0;
            r_beat_idx     <= '0;
            r_gap          <= '0;
            r_gap_cnt      <= '0;
            r_pkt_count    <= '0;
            r_pkts_sent    <= '0;
            r_beats_sent   <= '0;
            r_stop_pending <= 1'b0;
            r_tdata        <= '0;
            r_tvalid       <= 1'b0;
            r_tlast        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_tvalid <= (w_state_next == ST_SEND);
            r_busy   <= (w_state_next == ST_SEND) || (w_state_next == ST_GAP);
            r_done   <= (w_state_next == ST_DONE);

            if (w_start_ok) begin
                r_mode         <= w_cfg_mode;
                r_len          <= w_cfg_len;
                r_gap          <= cfg_gap;
                r_pkt_count    <= cfg_pkt_count;
                r_pkts_sent    <= '0;
                r_beats_sent   <= '0;
                r_beat_idx     <= '0;
                r_tdata        <= w_first_data;
                r_tlast        <= (w_cfg_len == LEN_BITS'(1));
                r_stop_pending <= 1'b0;
            end else begin
                if (r_state == ST_SEND && w_hs) begin
                    r_beats_sent <= r_beats_sent + CNT_BITS'(1);
                    r_beat_idx   <= w_beat_next;
                    r_pkts_sent  <= w_pkt_next;
                    r_tdata      <= w_data_next;
                    r_tlast      <= (w_beat_next == r_len - LEN_BITS'(1));
                    r_gap_cnt    <= r_gap;
                end
                if (r_state == ST_GAP) begin
                    r_gap_cnt <= r_gap_cnt - GAP_BITS'(1);
                end
                if (w_state_next == ST_IDLE) begin
                    r_stop_pending <= 1'b0;
                end else if (stop && (r_state == ST_SEND || r_state == ST_GAP)) begin
                    r_stop_pending <= 1'b1;
                end
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pkts_sent     = r_pkts_sent;
    assign beats_sent    = r_beats_sent;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Scoreboard bench for axis_pattern_gen: expected beats are queued at start and popped per handshake.
module tb_axis_pattern_gen;

    localparam int TDATA_BITS = 32;
    localparam int LEN_BITS   = 16;
    localparam int GAP_BITS   = 8;
    localparam int CNT_BITS   = 32;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic                  start;
    logic                  stop;
    logic [1:0]            cfg_mode;
    logic [TDATA_BITS-1:0] cfg_seed;
    logic [LEN_BITS-1:0]   cfg_pkt_len;
    logic [GAP_BITS-1:0]   cfg_gap;
    logic [CNT_BITS-1:0]   cfg_pkt_count;
    logic [TDATA_BITS-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;
    logic                  busy;
    logic                  done;
    logic [CNT_BITS-1:0]   pkts_sent;
    logic [CNT_BITS-1:0]   beats_sent;

    int n_vec = 0;
    int n_err = 0;

    logic [TDATA_BITS-1:0] exp_data_q[$];
    logic                  exp_last_q[$];
    logic                  valid_trace[$];

    always #5 aclk = ~aclk;

    axis_pattern_gen #(
        .TDATA_BITS (TDATA_BITS),
        .LEN_BITS   (LEN_BITS),
        .GAP_BITS   (GAP_BITS),
        .CNT_BITS   (CNT_BITS)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .stop          (stop),
        .cfg_mode      (cfg_mode),
        .cfg_seed      (cfg_seed),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_gap       (cfg_gap),
        .cfg_pkt_count (cfg_pkt_count),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .pkts_sent     (pkts_sent),
        .beats_sent    (beats_sent)
    );

    function automatic logic [31:0] model_lfsr(input logic [31:0] s);
        logic lsb;
        lsb = s[0];
        s   = s >> 1;
        if (lsb) s = s ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
        return s;
    endfunction

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Start pulse lasts one edge; config is then scrambled to prove it was latched.
    task automatic do_start(input logic [1:0] mode, input logic [31:0] seed, input logic [15:0] len,
                            input logic [7:0] gap, input logic [31:0] cnt);
        cfg_mode = mode; cfg_seed = seed; cfg_pkt_len = len; cfg_gap = gap; cfg_pkt_count = cnt;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        cfg_mode = 2'd2; cfg_seed = 32'hdead_beef; cfg_pkt_len = 16'd7; cfg_gap = 8'd9; cfg_pkt_count = 32'd1;
    endtask

    task automatic stream(input int budget, input bit rnd, input int stop_at, input int start_at,
                          output int beats);
        bit                    prev_stall = 1'b0;
        logic [TDATA_BITS-1:0] prev_data  = '0;
        logic                  prev_last  = 1'b0;
        bit                    stop_done  = 1'b0;
        bit                    start_done = 1'b0;
        bit                    finished   = 1'b0;
        logic [TDATA_BITS-1:0] ed;
        logic                  el;
        beats = 0;
        valid_trace.delete();
        for (int c = 0; c < budget && !finished; c++) begin
            start = 1'b0;
            stop  = 1'b0;
            if (stop_at >= 0 && beats == stop_at && !stop_done) begin
                stop = 1'b1; stop_done = 1'b1;
            end
            if (start_at >= 0 && beats == start_at && !start_done) begin
                start = 1'b1; start_done = 1'b1;
                cfg_mode = 2'd1; cfg_seed = 32'h5555; cfg_pkt_len = 16'd2; cfg_pkt_count = 32'd1;
            end
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            valid_trace.push_back(m_axis_tvalid);
            if (prev_stall) begin
                n_vec++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
                    n_err++;
                    $display("FAIL stall_hold: got valid %b data %h last %b, expected valid 1 data %h last %b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                beats++;
                n_vec++;
                if (exp_data_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_%0d: got data %h with no beat expected", beats, m_axis_tdata);
                end else begin
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    if (m_axis_tdata !== ed || m_axis_tlast !== el) begin
                        n_err++;
                        $display("FAIL beat_%0d: got data %h last %b, expected data %h last %b",
                                 beats, m_axis_tdata, m_axis_tlast, ed, el);
                    end
                end
            end
            if (beats > 0 && !busy) finished = 1'b1;
            @(posedge aclk); #1;
        end
        start = 1'b0;
        stop  = 1'b0;
        n_vec++;
        if (!finished) begin
            n_err++;
            $display("FAIL stream_timeout: got run still busy after %0d cycles, expected completion", budget);
        end
    endtask

    task automatic check_drained(input string name);
        check_val({name, "_leftover"}, 64'(exp_data_q.size()), 64'd0);
        exp_data_q.delete();
        exp_last_q.delete();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check_val("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("rst_tdata",  64'(m_axis_tdata),  64'd0);
        check_val("rst_tlast",  64'(m_axis_tlast),  64'd0);
        check_val("rst_busy",   64'(busy),          64'd0);
        check_val("rst_done",   64'(done),          64'd0);
        check_val("rst_pkts",   64'(pkts_sent),     64'd0);
        check_val("rst_beats",  64'(beats_sent),    64'd0);
        areset = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic test_counter_b2b();
        int beats;
        for (int i = 0; i < 8; i++) begin
            exp_data_q.push_back(32'h10 + 32'(i));
            exp_last_q.push_back(i % 4 == 3);
        end
        m_axis_tready = 1'b1;
        do_start(2'd0, 32'h10, 16'd4, 8'd0, 32'd2);
        check_val("b2b_first_valid", 64'(m_axis_tvalid), 64'd1);
        check_val("b2b_first_data",  64'(m_axis_tdata),  64'h10);
        stream(100, 1'b0, -1, -1, beats);
        check_val("b2b_beats_seen", 64'(beats), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check_val("b2b_valid_cont", 64'(valid_trace[i]), 64'd1);
        end
        check_val("b2b_done",       64'(done),          64'd1);
        check_val("b2b_tvalid_off", 64'(m_axis_tvalid), 64'd0);
        check_val("b2b_pkts",       64'(pkts_sent),     64'd2);
        check_val("b2b_beats",      64'(beats_sent),    64'd8);
        check_drained("b2b");
    endtask

    task automatic test_gap();
        int beats;
        logic exp_tr [14] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
        for (int i = 0; i < 9; i++) begin
            exp_data_q.push_back(32'(i));
            exp_last_q.push_back(i % 3 == 2);
        end
        do_start(2'd0, 32'h0, 16'd3, 8'd2, 32'd3);
        stream(100, 1'b0, -1, -1, beats);
        check_val("gap_trace_len", 64'(valid_trace.size()), 64'd14);
        for (int i = 0; i < 14 && i < valid_trace.size(); i++) begin
            check_val("gap_trace", 64'(valid_trace[i]), 64'(exp_tr[i]));
        end
        check_val("gap_pkts", 64'(pkts_sent), 64'd3);
        check_val("gap_done", 64'(done),      64'd1);
        check_drained("gap");
    endtask

    task automatic test_lfsr_random();
        int          beats;
        logic [31:0] s = 32'h1;
        for (int i = 0; i < 20; i++) begin
            exp_data_q.push_back(s);
            exp_last_q.push_back(i % 5 == 4);
            s = model_lfsr(s);
        end
        do_start(2'd1, 32'h0, 16'd5, 8'd1, 32'd4);
        stream(600, 1'b1, -1, -1, beats);
        check_val("lfsr_beats", 64'(beats_sent), 64'd20);
        check_val("lfsr_pkts",  64'(pkts_sent),  64'd4);
        check_drained("lfsr");
    endtask

    task automatic test_index_stop();
        int beats;
        for (int k = 0; k < 40; k++) begin
            exp_data_q.push_back({16'(k), 16'h0});
            exp_last_q.push_back(1'b1);
        end
        m_axis_tready = 1'b1;
        do_start(2'd2, 32'hffff_ffff, 16'd0, 8'd0, 32'd0);
        stream(200, 1'b0, 5, -1, beats);
        check_val("stop_beats_seen", 64'(beats),         64'd6);
        check_val("stop_pkts",       64'(pkts_sent),     64'd6);
        check_val("stop_beats",      64'(beats_sent),    64'd6);
        check_val("stop_busy",       64'(busy),          64'd0);
        check_val("stop_done",       64'(done),          64'd0);
        check_val("stop_tvalid",     64'(m_axis_tvalid), 64'd0);
        exp_data_q.delete();
        exp_last_q.delete();
    endtask

    task automatic test_reset_mid_packet();
        int beats;
        m_axis_tready = 1'b1;
        do_start(2'd0, 32'h100, 16'd4, 8'd0, 32'd1);
        @(negedge aclk);
        check_val("mid_beat0", 64'(m_axis_tdata), 64'h100);
        @(posedge aclk); #1;
        @(negedge aclk);
        check_val("mid_beat1", 64'(m_axis_tdata), 64'h101);
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        check_val("mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_val("mid_tdata",  64'(m_axis_tdata),  64'd0);
        check_val("mid_pkts",   64'(pkts_sent),     64'd0);
        check_val("mid_beats",  64'(beats_sent),    64'd0);
        check_val("mid_busy",   64'(busy),          64'd0);
        areset = 1'b0;
        @(posedge aclk); #1;
        for (int i = 0; i < 4; i++) begin
            exp_data_q.push_back(32'h100 + 32'(i));
            exp_last_q.push_back(i == 3);
        end
        do_start(2'd0, 32'h100, 16'd4, 8'd0, 32'd1);
        stream(100, 1'b0, -1, -1, beats);
        check_val("mid_restart_beats", 64'(beats_sent), 64'd4);
        check_val("mid_restart_done",  64'(done),       64'd1);
        check_drained("mid");
    endtask

    task automatic test_start_ignored();
        int beats;
        for (int i = 0; i < 6; i++) begin
            exp_data_q.push_back(32'h40 + 32'(i));
            exp_last_q.push_back(i % 3 == 2);
        end
        do_start(2'd0, 32'h40, 16'd3, 8'd0, 32'd2);
        stream(100, 1'b0, -1, 2, beats);
        check_val("ign_beats", 64'(beats_sent), 64'd6);
        check_val("ign_pkts",  64'(pkts_sent),  64'd2);
        check_val("ign_done",  64'(done),       64'd1);
        check_drained("ign");
    endtask

    initial begin
        areset        = 1'b1;
        start         = 1'b0;
        stop          = 1'b0;
        cfg_mode      = 2'd0;
        cfg_seed      = '0;
        cfg_pkt_len   = '0;
        cfg_gap       = '0;
        cfg_pkt_count = '0;
        m_axis_tready = 1'b0;
        test_reset();
        test_counter_b2b();
        test_gap();
        test_lfsr_random();
        test_index_stop();
        test_reset_mid_packet();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_pattern_gen.md
# axis_pattern_gen

- Parametrised AXI4-Stream traffic generator; successor to the free-running counter source.
- Emits framed packets with `m_axis_tlast`, runtime-selectable packet length, inter-packet gap, packet count and data pattern (counter, LFSR, index).
- Sits upstream of the CDC/FIFO and PS–PL stream paths in the timing demos as a deterministic, checkable stimulus source.
- Reports progress counters for PS readout.

## Interface
- `TDATA_BITS`, 32: stream data width, ≥16, even.
- `LEN_BITS`, 16: width of the packet-length and beat-index fields.
- `GAP_BITS`, 8: width of the inter-packet gap field.
- `CNT_BITS`, 32: width of the packet-count and status counters.

Ports (clock and reset first):
- `aclk`  in  1  sole clock; all logic on rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; latches config, begins run; ignored unless IDLE or DONE.
- `stop`  in  1  pulse; finish current packet, then go to IDLE.
- `cfg_mode`  in  2  0 = counter, 1 = LFSR, 2 = index, 3 = reserved (treated as 0).
- `cfg_seed`  in  TDATA_BITS  first data value (counter) or LFSR seed.
- `cfg_pkt_len`  in  LEN_BITS  beats per packet; 0 is treated as 1.
- `cfg_gap`  in  GAP_BITS  idle cycles between packets.
- `cfg_pkt_count`  in  CNT_BITS  packets per run; 0 means unlimited.
- `m_axis_tdata`  out  TDATA_BITS  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tlast`  out  1  last beat of packet.
- `m_axis_tready`  in  1  sink ready.
- `busy`  out  1  high in SEND or GAP.
- `done`  out  1  high in DONE.
- `pkts_sent`  out  CNT_BITS  completed packets in the current run.
- `beats_sent`  out  CNT_BITS  handshaken beats in the current run.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE / DONE + `start`:
  - latch all `cfg_*`;
  - clear `pkts_sent` and `beats_sent`;
  - load the pattern register;
  - go to SEND.
- SEND: `tvalid` = 1. On handshake (`tvalid & tready`):
  - advance pattern; increment beat index and `beats_sent`.
  - On a `tlast` beat: increment `pkts_sent`, clear beat index, then pick the next state in priority order:
    1. DONE if the count is reached (`pkt_count ≠ 0` and `pkts_sent + 1 == pkt_count`);
    2. IDLE if a stop is pending;
    3. GAP if `gap > 0`;
    4. otherwise stay in SEND.
- GAP: `tvalid` = 0.
  - Count `gap` cycles, then go to SEND.
  - If a stop is pending, go to IDLE instead.
- `stop`:
  - Sets a sticky pending flag in SEND/GAP; never truncates a packet.
  - Pending flag clears on entering IDLE.
  - No effect in IDLE/DONE.
- Patterns (per handshaken beat, continuous across packets):
  - Mode 0: data = seed, seed+1, …, wrapping mod 2^TDATA_BITS.
  - Mode 1: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, shift once per beat.
    - Seed 0 is replaced by 1.
    - Data = LFSR zero-extended or truncated to TDATA_BITS.
  - Mode 2: upper half = packet index (mod 2^(TDATA_BITS/2)); lower half = beat index within packet; seed ignored.
- `tlast` = 1 exactly when beat index == `pkt_len` − 1.
- Config inputs are sampled only at `start`; mid-run changes have no effect.

## Timing
- All outputs are registered.
- Reset values: `tdata` = 0, `tvalid` = 0, `tlast` = 0, `busy` = 0, `done` = 0, counters = 0, state IDLE.
- `start` at cycle N → first `tvalid` at N+1 with the first pattern value.
- AXIS rules:
  - Once `tvalid` is high, `tdata` and `tlast` hold stable until handshake.
  - `tvalid` never drops without a handshake.
- Back-to-back throughput: 1 beat/cycle with `tready` held high.
- `gap` = G: last handshake at cycle N → `tvalid` low for cycles N+1..N+G, high again at N+G+1.
- `gap` = 0: `tvalid` continuous across packet boundaries.
- DONE / IDLE exit: `tvalid` low from the cycle after the final handshake.
- `done` holds until the next `start` or reset.
- `start` and `stop` in the same cycle from IDLE: start wins; the stop is ignored.
- `areset` mid-packet: outputs return to reset values on the next edge. No packet completion is required.

## Structure
- Shared package (`axis_gen_pkg`):
  - mode encodings;
  - FSM state encoding;
  - LFSR polynomial constant.
- One sub-module: `lfsr32_galois`, with inputs `aclk`, `areset`, `load`, `seed` (zero mapped to 1), `step` and output `q`.
- Counter and index patterns stay inline.

## Test plan
- Mode 0, seed 0x10, `pkt_len` 4, `gap` 0, `pkt_count` 2, `tready` = 1 → data 0x10..0x17; `tlast` on 0x13 and 0x17; `done` after 8 beats; `pkts_sent` = 2, `beats_sent` = 8.
- Mode 0, `pkt_len` 3, `gap` 2, `pkt_count` 3 → `tvalid` pattern 111 00 111 00 111; no `tvalid` after the 9th beat.
- Random `tready` (~50% duty), mode 1, seed 0 → scoreboard matches the LFSR model seeded with 1; `tdata`/`tlast` stable while `tvalid & !tready`.
- Mode 2, `pkt_len` 0, `pkt_count` 0, `stop` after 5 beats → single-beat packets with data {k,0}; run ends after the current packet; state IDLE, `done` = 0.
- Assert `areset` mid-packet (beat 2 of 4) → next cycle `tvalid` = 0 and counters = 0; a following `start` restarts from the seed.
- `start` pulsed during SEND with different config → ignored; the original sequence continues unchanged.
